led_blink_seq: RTL and testbench
================================

LED_BLINK_SEQ -- requirements
Module: led_blink_seq

Interface
REQ-001 Parameter: TICK_DIV, default 50000, clocks per timing tick (1 kHz tick at 50 MHz); legal range 2..2^24.
REQ-002 Parameter: TIME_W, default 16, width of on/off time fields in ticks.
REQ-003 Parameter: CNT_W, default 8, width of blink count field.
REQ-004 Port: clk  input  1  the block's only clock; all logic on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  request to begin a blink sequence, sampled each clk.
REQ-007 Port: stop  input  1  abort the running sequence.
REQ-008 Port: on_time  input  TIME_W  LED-active phase length in ticks, latched at start.
REQ-009 Port: off_time  input  TIME_W  LED-inactive phase length in ticks, latched at start.
REQ-010 Port: blink_cnt  input  CNT_W  number of on/off cycles, latched at start; 0 = run until stop.
REQ-011 Port: polarity  input  1  latched at start; 1 = active-low LED (output inverted).
REQ-012 Port: led  output  1  registered LED drive.
REQ-013 Port: busy  output  1  high in any state other than IDLE.
REQ-014 Port: done  output  1  one-cycle pulse on normal sequence completion.

Function
REQ-015 FSM states SHALL be IDLE, ON, OFF and DONE; state, led, busy and done SHALL be registered and update on the same edge.
REQ-016 In IDLE, start=1 with stop=0 SHALL latch on_time, off_time, blink_cnt and polarity and enter ON on that edge.
REQ-017 start SHALL be ignored while busy=1; latched fields SHALL NOT change until the next accepted start.
REQ-018 A latched on_time or off_time of 0 SHALL be treated as 1 tick.
REQ-019 A prescaler SHALL count 0..TICK_DIV-1 and restart at 0 on every phase entry, so each phase lasts exactly (time x TICK_DIV) clocks.
REQ-020 A per-phase tick counter SHALL count prescaler wraps; ON SHALL exit to OFF when it reaches the latched on_time.
REQ-021 OFF SHALL exit when the tick counter reaches the latched off_time, incrementing a CNT_W-bit completed-blink counter.
REQ-022 On OFF exit, if latched blink_cnt != 0 and the incremented count equals blink_cnt, the FSM SHALL enter DONE; otherwise it SHALL re-enter ON.
REQ-023 With blink_cnt = 0 the completed-blink counter SHALL wrap modulo 2^CNT_W with no effect on sequencing.
REQ-024 DONE SHALL last exactly one cycle with done=1, then go to IDLE; done SHALL be 0 in every other state.
REQ-025 led SHALL equal (state==ON) XOR latched polarity; in IDLE and DONE led SHALL sit at the inactive level (= latched polarity).
REQ-026 stop=1 in ON, OFF or DONE SHALL force IDLE on the next edge, set led inactive, and suppress done.
REQ-027 stop=1 and start=1 together in IDLE: stop SHALL win and the start SHALL be dropped.
REQ-028 busy SHALL be 1 in ON, OFF and DONE, and 0 in IDLE.

Reset
REQ-029 rst=1 SHALL override all inputs, including start and stop, on the same edge.
REQ-030 Reset SHALL force IDLE, led=0, busy=0 and done=0, latched polarity=0, and clear the prescaler, tick counter and blink counter.
REQ-031 rst asserted mid-sequence SHALL abort with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification (TICK_DIV=4)
REQ-032 Bench: on=2, off=1, cnt=2, pol=0, start pulse -> led high 8 clk, low 4 clk, high 8, low 4; done for 1 clk; busy falls with done.
REQ-033 Bench: pol=1, same run -> led is the exact inverse of REQ-032's led; led=1 in IDLE afterwards.
REQ-034 Bench: cnt=0, on=1, off=1 -> led toggles every 4 clk for 300 blinks (counter wrap); done never asserts; stop -> IDLE next edge, led inactive.
REQ-035 Bench: start and stop both high in IDLE -> busy stays 0; start pulses while busy with changed inputs -> timing unchanged.
REQ-036 Bench: on=0, off=0, cnt=1 -> led active 4 clk, inactive 4 clk, then done.
REQ-037 Bench: rst pulsed during ON -> next cycle led=0, busy=0, no done; a new start then runs a full sequence.

Source files
------------

// File: rtl/led_blink_seq.sv
// LED blink sequencer: ON/OFF phases timed in prescaled ticks, repeated a
// programmable number of times (or forever), with abort and polarity control.
module led_blink_seq #(
  parameter int unsigned TICK_DIV = 50000,
  parameter int unsigned TIME_W   = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [TIME_W-1:0] on_time,
  input  logic [TIME_W-1:0] off_time,
  input  logic [CNT_W-1:0]  blink_cnt,
  input  logic              polarity,
  output logic              led,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TICK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

  state_e state_q, state_d;

  logic [TIME_W-1:0] on_q, on_d, off_q, off_d;
  logic [CNT_W-1:0]  blk_q, blk_d, cnt_q, cnt_d;
  logic              pol_q, pol_d;
  logic [PreW-1:0]   pre_q, pre_d;
  logic [TIME_W-1:0] tick_q, tick_d;
  logic              led_q, led_d, busy_q, busy_d, done_q, done_d;

  logic [TIME_W-1:0] on_eff, off_eff, phase_len;
  logic              tick_wrap, phase_end;

  always_comb begin
    state_d = state_q;
    on_d    = on_q;
    off_d   = off_q;
    blk_d   = blk_q;
    pol_d   = pol_q;
    pre_d   = pre_q;
    tick_d  = tick_q;
    cnt_d   = cnt_q;

    // Zero-length phases are stretched to a single tick.
    on_eff    = (on_q == '0) ? TIME_W'(1) : on_q;
    off_eff   = (off_q == '0) ? TIME_W'(1) : off_q;
    phase_len = (state_q == StOn) ? on_eff : off_eff;
    tick_wrap = (pre_q == PreMax);
    phase_end = tick_wrap && (tick_q == phase_len - TIME_W'(1));

    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          on_d    = on_time;
          off_d   = off_time;
          blk_d   = blink_cnt;
          pol_d   = polarity;
          cnt_d   = '0;
          pre_d   = '0;
          tick_d  = '0;
          state_d = StOn;
        end
      end
      StOn, StOff: begin
        if (stop) begin
          state_d = StIdle;
        end else if (phase_end) begin
          pre_d  = '0;
          tick_d = '0;
          if (state_q == StOn) begin
            state_d = StOff;
          end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = ((blk_q != '0) && (cnt_d == blk_q)) ? StDone : StOn;
          end
        end else if (tick_wrap) begin
          pre_d  = '0;
          tick_d = tick_q + TIME_W'(1);
        end else begin
          pre_d = pre_q + PreW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they move with state.
    led_d  = (state_d == StOn) ^ pol_d;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      on_q    <= '0;
      off_q   <= '0;
      blk_q   <= '0;
      pol_q   <= 1'b0;
      pre_q   <= '0;
      tick_q  <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      on_q    <= on_d;
      off_q   <= off_d;
      blk_q   <= blk_d;
      pol_q   <= pol_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_blink_seq.sv
// Directed bench for led_blink_seq at TICK_DIV=4; expected {led,busy,done}
// per cycle is queued when stimulus is applied and checked after each edge.
`timescale 1ns/1ps
module tb_led_blink_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] on_time = '0;
  logic [15:0] off_time = '0;
  logic [7:0]  blink_cnt = '0;
  logic        polarity = 1'b0;
  logic        led, busy, done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [2:0] v;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  led_blink_seq #(
    .TICK_DIV(4),
    .TIME_W  (16),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .on_time  (on_time),
    .off_time (off_time),
    .blink_cnt(blink_cnt),
    .polarity (polarity),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  task automatic push(input int n, input logic l, input logic b, input logic d,
                      input string tag);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.v   = {l, b, d};
      e.tag = tag;
      exp_q.push_back(e);
    end
  endtask

  // Full finite run: blinks x (on, off) clocks, one done cycle, then idle.
  task automatic push_seq(input int on_clk, input int off_clk, input int blinks,
                          input logic pol, input string tag);
    for (int i = 0; i < blinks; i++) begin
      push(on_clk, ~pol, 1'b1, 1'b0, tag);
      push(off_clk, pol, 1'b1, 1'b0, tag);
    end
    push(1, pol, 1'b1, 1'b1, tag);
    push(1, pol, 1'b0, 1'b0, tag);
  endtask

  // Pulsed controls are dropped right after the edge that sampled them.
  task automatic step();
    exp_t       e;
    logic [2:0] obs;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    rst   = 1'b0;
    obs   = {led, busy, done};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL underflow: observed {led,busy,done}=%b with no expected entry", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.v) else begin
        miscompares++;
        $error("FAIL %s: cycle %0d observed {led,busy,done}=%b required %b",
               e.tag, vectors, obs, e.v);
      end
    end
  endtask

  task automatic drain();
    while (exp_q.size() > 0) step();
  endtask

  task automatic go(input int on_t, input int off_t, input int cnt, input logic pol);
    on_time   = 16'(on_t);
    off_time  = 16'(off_t);
    blink_cnt = 8'(cnt);
    polarity  = pol;
    start     = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset, with start held to show reset overrides it.
    rst   = 1'b1;
    start = 1'b1;
    push(1, 1'b0, 1'b0, 1'b0, "reset");
    step();
    push(1, 1'b0, 1'b0, 1'b0, "reset_idle");
    drain();

    // Basic run, active-high LED.
    go(2, 1, 2, 1'b0);
    push_seq(8, 4, 2, 1'b0, "basic_pol0");
    drain();

    // Same run with inverted LED; idle level afterwards is 1.
    go(2, 1, 2, 1'b1);
    push_seq(8, 4, 2, 1'b1, "basic_pol1");
    drain();

    // Continuous mode past the 8-bit counter wrap, then stop.
    go(1, 1, 0, 1'b0);
    for (int i = 0; i < 300; i++) begin
      push(4, 1'b1, 1'b1, 1'b0, "continuous");
      push(4, 1'b0, 1'b1, 1'b0, "continuous");
    end
    drain();
    stop = 1'b1;
    push(1, 1'b0, 1'b0, 1'b0, "stop_abort");
    push(1, 1'b0, 1'b0, 1'b0, "stop_idle");
    drain();

    // start with stop in IDLE is dropped.
    go(2, 2, 1, 1'b0);
    stop = 1'b1;
    push(3, 1'b0, 1'b0, 1'b0, "start_stop");
    drain();

    // start pulses with changed fields while busy, including in DONE.
    go(1, 2, 1, 1'b0);
    push_seq(4, 8, 1, 1'b0, "busy_ignore");
    for (int k = 0; k < 14; k++) begin
      if (k == 3 || k == 8 || k == 13) go(5, 5, 3, 1'b1);
      step();
    end
    drain();

    // Zero phase lengths act as one tick.
    go(0, 0, 1, 1'b0);
    push_seq(4, 4, 1, 1'b0, "zero_time");
    drain();

    // Reset mid-ON aborts with no done and clears latched polarity.
    go(2, 1, 2, 1'b1);
    push(3, 1'b0, 1'b1, 1'b0, "pre_rst_on");
    drain();
    rst   = 1'b1;
    start = 1'b1;
    push(1, 1'b0, 1'b0, 1'b0, "rst_mid");
    push(2, 1'b0, 1'b0, 1'b0, "rst_idle");
    drain();
    go(2, 1, 2, 1'b0);
    push_seq(8, 4, 2, 1'b0, "after_rst");
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
